// File: rtl/pe_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_link_pkg
//  Brief    : Shared widths and helpers for the PE stream link endpoint.
//  Revision : 1.0 - initial release
// ============================================================================
package pe_link_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_link_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pe_link_rx_fifo
//  Brief    : First-word-fall-through RX FIFO with occupancy threshold flag
//             and sticky overflow indication.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_link_rx_fifo
    import pe_link_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SLACK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_accept,
    output logic              o_bp,
    output logic              o_ovf
);

    localparam int                 c_aw     = clog2(DEPTH);
    localparam logic [c_aw:0]      c_full   = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]      c_thresh = (c_aw + 1)'(DEPTH - SLACK);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wp;
    logic [c_aw-1:0]   r_rp;
    logic [c_aw:0]     r_cnt;
    logic [c_aw:0]     w_cnt_next;
    logic              w_pop;
    logic              w_push_ok;
    logic              r_bp;
    logic              r_ovf;

    assign o_valid   = (r_cnt != '0);
    assign o_data    = r_mem[r_rp];
    assign w_pop     = o_valid & i_pop_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_push_ok = i_push & ((r_cnt != c_full) | w_pop);
    assign o_accept  = w_push_ok;
    assign o_bp      = r_bp;
    assign o_ovf     = r_ovf;

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_push_ok, w_pop})
            2'b10:   w_cnt_next = r_cnt + 1'b1;
            2'b01:   w_cnt_next = r_cnt - 1'b1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_bp  <= 1'b1;
            r_ovf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= w_cnt_next;
            r_bp  <= (w_cnt_next >= c_thresh);
            if (i_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_link_port.sv
`default_nettype none
// ============================================================================
//  Module   : pe_link_port
//  Brief    : Host-side PE link endpoint: registered TX stage onto D/D_VALID
//             with D_BP throttling, and a buffered FWFT RX path from Q.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_link_port
    import pe_link_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int RX_SLACK = 4
) (
    input  logic              CLK,
    input  logic              SYS_RST,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [DATA_W-1:0] D,
    output logic              D_VALID,
    input  logic              D_BP,
    input  logic [DATA_W-1:0] Q,
    input  logic              Q_VALID,
    output logic              Q_BP,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [CNT_W-1:0]  TX_WORDS,
    output logic [CNT_W-1:0]  RX_WORDS,
    output logic              RX_OVF
);

    logic              r_bp;
    logic [DATA_W-1:0] r_d;
    logic              r_d_valid;
    logic [CNT_W-1:0]  r_tx_words;
    logic [CNT_W-1:0]  r_rx_words;
    logic [DATA_W-1:0] r_qr;
    logic              r_qvr;
    logic              w_tx_acc;
    logic              w_rx_acc;

    // D_BP only reaches the outputs through r_bp, bounding the overrun to 2 words.
    assign S_READY  = ~r_bp;
    assign w_tx_acc = S_VALID & ~r_bp;

    assign D        = r_d;
    assign D_VALID  = r_d_valid;
    assign TX_WORDS = r_tx_words;
    assign RX_WORDS = r_rx_words;

    always_ff @(posedge CLK) begin
        if (SYS_RST) begin
            r_bp       <= 1'b1;
            r_d        <= '0;
            r_d_valid  <= 1'b0;
            r_tx_words <= '0;
            r_rx_words <= '0;
            r_qr       <= '0;
            r_qvr      <= 1'b0;
        end else begin
            r_bp      <= D_BP;
            r_d_valid <= w_tx_acc;
            if (w_tx_acc) begin
                r_d        <= S_DATA;
                r_tx_words <= r_tx_words + 1'b1;
            end
            r_qr  <= Q;
            r_qvr <= Q_VALID;
            if (w_rx_acc) begin
                r_rx_words <= r_rx_words + 1'b1;
            end
        end
    end

    pe_link_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .SLACK (RX_SLACK)
    ) u_rx_fifo (
        .clk         (CLK),
        .rst         (SYS_RST),
        .i_push      (r_qvr),
        .i_data      (r_qr),
        .i_pop_ready (M_READY),
        .o_data      (M_DATA),
        .o_valid     (M_VALID),
        .o_accept    (w_rx_acc),
        .o_bp        (Q_BP),
        .o_ovf       (RX_OVF)
    );

endmodule
`default_nettype wire

// File: tb/tb_pe_link_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_link_port
//  Brief    : Directed self-checking bench for pe_link_port (TX and RX paths).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_link_port;

    logic        CLK = 1'b0;
    logic        SYS_RST;
    logic [63:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic [63:0] D;
    logic        D_VALID;
    logic        D_BP;
    logic [63:0] Q;
    logic        Q_VALID;
    logic        Q_BP;
    logic [63:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic [31:0] TX_WORDS;
    logic [31:0] RX_WORDS;
    logic        RX_OVF;

    int n_vec = 0;
    int n_err = 0;

    // Reference state, advanced one clock at a time.
    logic        m_bpr;
    logic        m_dv;
    logic [63:0] m_d;
    logic [31:0] m_tx;
    logic        m_qvr;
    logic [63:0] m_qr;
    logic [63:0] m_fifo [$];
    logic [31:0] m_rxw;
    logic        m_ovf;
    logic        m_qbp;
    int          sent;

    always #5 CLK = ~CLK;

    pe_link_port #(
        .RX_DEPTH (16),
        .RX_SLACK (4)
    ) dut (
        .CLK      (CLK),
        .SYS_RST  (SYS_RST),
        .S_DATA   (S_DATA),
        .S_VALID  (S_VALID),
        .S_READY  (S_READY),
        .D        (D),
        .D_VALID  (D_VALID),
        .D_BP     (D_BP),
        .Q        (Q),
        .Q_VALID  (Q_VALID),
        .Q_BP     (Q_BP),
        .M_DATA   (M_DATA),
        .M_VALID  (M_VALID),
        .M_READY  (M_READY),
        .TX_WORDS (TX_WORDS),
        .RX_WORDS (RX_WORDS),
        .RX_OVF   (RX_OVF)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bpr = 1'b1;
        m_dv  = 1'b0;
        m_d   = '0;
        m_tx  = '0;
        m_qvr = 1'b0;
        m_qr  = '0;
        m_fifo.delete();
        m_rxw = '0;
        m_ovf = 1'b0;
        m_qbp = 1'b1;
    endtask

    // One clock: predict from pre-edge inputs, then compare every output.
    task automatic cycle();
        bit acc, pop, push, room;
        acc  = S_VALID && !m_bpr;
        pop  = M_READY && (m_fifo.size() != 0);
        push = m_qvr;
        room = (m_fifo.size() < 16) || pop;
        @(posedge CLK);
        #1;
        if (SYS_RST) begin
            model_reset();
        end else begin
            m_bpr = D_BP;
            m_dv  = acc;
            if (acc) begin
                m_d  = S_DATA;
                m_tx = m_tx + 1;
            end
            if (pop) void'(m_fifo.pop_front());
            if (push && room) begin
                m_fifo.push_back(m_qr);
                m_rxw = m_rxw + 1;
            end else if (push) begin
                m_ovf = 1'b1;
            end
            m_qbp = (m_fifo.size() >= 12);
            m_qvr = Q_VALID;
            m_qr  = Q;
        end
        check("s_ready",  S_READY,  !m_bpr);
        check("d_valid",  D_VALID,  m_dv);
        check("d",        D,        m_d);
        check("tx_words", TX_WORDS, m_tx);
        check("q_bp",     Q_BP,     m_qbp);
        check("rx_ovf",   RX_OVF,   m_ovf);
        check("rx_words", RX_WORDS, m_rxw);
        check("m_valid",  M_VALID,  m_fifo.size() != 0);
        if (m_fifo.size() != 0) check("m_data", M_DATA, m_fifo[0]);
    endtask

    task automatic do_reset();
        S_VALID = 1'b0;
        D_BP    = 1'b0;
        Q_VALID = 1'b0;
        M_READY = 1'b0;
        SYS_RST = 1'b1;
        repeat (2) cycle();
        SYS_RST = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SYS_RST = 1'b1;
        S_VALID = 1'b1;
        S_DATA  = '0;
        D_BP    = 1'b0;
        Q       = '0;
        Q_VALID = 1'b0;
        M_READY = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
        repeat (2) cycle();

        // Reset release
        SYS_RST = 1'b0;
        check("rel0_s_ready", S_READY, 1'b0);
        check("rel0_q_bp",    Q_BP,    1'b1);
        cycle();
        check("rel1_s_ready", S_READY, 1'b1);
        check("rel1_q_bp",    Q_BP,    1'b0);
        check("rel1_d_valid", D_VALID, 1'b0);

        // TX streaming 0..99
        for (int i = 0; i < 120 && m_tx < 100; i++) begin
            S_DATA = 64'(m_tx);
            cycle();
        end
        check("stream_tx_words", TX_WORDS, 100);
        check("stream_last_d",   D,        99);

        // TX backpressure: D_BP high for loop cycles 5..9
        for (int c = 0; c < 20; c++) begin
            D_BP   = (c >= 5 && c < 10);
            S_DATA = 64'(m_tx);
            cycle();
            if (c == 5) check("bp_t1_dv", D_VALID, 1'b1);
            if (c >= 6 && c <= 10) check("bp_dv_low", D_VALID, 1'b0);
        end
        S_VALID = 1'b0;
        D_BP    = 1'b0;
        cycle();
        check("bp_tx_words", TX_WORDS, 115);
        check("bp_last_d",   D,        114);

        // RX fill with a sender that honours Q_BP
        do_reset();
        sent = 0;
        for (int i = 0; i < 20; i++) begin
            Q_VALID = !Q_BP && (sent < 16);
            Q       = 64'(sent);
            cycle();
            if (Q_VALID) sent++;
        end
        Q_VALID = 1'b0;
        check("fill_sent",     sent,     13);
        check("fill_rx_words", RX_WORDS, 13);
        check("fill_rx_ovf",   RX_OVF,   1'b0);
        check("fill_q_bp",     Q_BP,     1'b1);
        check("fill_head",     M_DATA,   0);
        M_READY = 1'b1;
        repeat (13) cycle();
        M_READY = 1'b0;
        check("drain_m_valid", M_VALID, 1'b0);
        check("drain_q_bp",    Q_BP,    1'b0);

        // RX overflow: 20 words, Q_BP ignored
        do_reset();
        for (int i = 0; i < 20; i++) begin
            Q_VALID = 1'b1;
            Q       = 64'(200 + i);
            cycle();
        end
        Q_VALID = 1'b0;
        repeat (2) cycle();
        check("ovf_rx_words", RX_WORDS, 16);
        check("ovf_rx_ovf",   RX_OVF,   1'b1);
        check("ovf_head",     M_DATA,   200);
        M_READY = 1'b1;
        repeat (16) cycle();
        M_READY = 1'b0;
        check("ovf_drained", M_VALID, 1'b0);
        check("ovf_sticky",  RX_OVF,  1'b1);

        // Push at full with a concurrent pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            Q_VALID = 1'b1;
            Q       = 64'(300 + i);
            cycle();
        end
        Q_VALID = 1'b0;
        repeat (2) cycle();
        check("full_rx_words", RX_WORDS, 16);
        Q_VALID = 1'b1;
        Q       = 64'd400;
        cycle();
        Q_VALID = 1'b0;
        M_READY = 1'b1;
        cycle();
        M_READY = 1'b0;
        cycle();
        check("pp_rx_ovf",   RX_OVF,   1'b0);
        check("pp_rx_words", RX_WORDS, 17);
        check("pp_head",     M_DATA,   301);
        M_READY = 1'b1;
        repeat (16) cycle();
        M_READY = 1'b0;
        check("pp_drained", M_VALID, 1'b0);

        // Mid-operation reset
        do_reset();
        S_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Q_VALID = 1'b1;
            Q       = 64'(500 + i);
            S_DATA  = 64'(m_tx);
            cycle();
        end
        Q       = 64'd999;
        S_DATA  = 64'(m_tx);
        cycle();
        check("pre_rst_dv",  D_VALID,  1'b1);
        check("pre_rst_rxw", RX_WORDS, 10);
        SYS_RST = 1'b1;
        Q_VALID = 1'b0;
        cycle();
        check("mrst_m_valid",  M_VALID,  1'b0);
        check("mrst_d_valid",  D_VALID,  1'b0);
        check("mrst_tx_words", TX_WORDS, 0);
        check("mrst_rx_words", RX_WORDS, 0);
        check("mrst_rx_ovf",   RX_OVF,   1'b0);
        S_VALID = 1'b0;
        SYS_RST = 1'b0;
        repeat (3) cycle();
        check("post_m_valid",  M_VALID,  1'b0);
        check("post_rx_words", RX_WORDS, 0);
        check("post_d_valid",  D_VALID,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
